// File: rtl/spi_fnd_slave.sv
// SPI slave that receives a 2-byte frame (two 0..99 values) and shows it on a
// 4-digit multiplexed 7-segment display with active-low digit and segment drives.
module spi_fnd_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int SCAN_DIV    = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       SS_N,
   output logic       MISO,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data,
   output logic       frame_valid,
   output logic       frame_err
);

   localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX_HIGH  = 3'd1,
      RX_LOW   = 3'd2,
      WAIT_END = 3'd3,
      COMMIT   = 3'd4
   } state_t;

   function automatic logic [7:0] seg7(input logic [7:0] v);
      case (v)
         8'd0:    seg7 = 8'hC0;
         8'd1:    seg7 = 8'hF9;
         8'd2:    seg7 = 8'hA4;
         8'd3:    seg7 = 8'hB0;
         8'd4:    seg7 = 8'h99;
         8'd5:    seg7 = 8'h92;
         8'd6:    seg7 = 8'h82;
         8'd7:    seg7 = 8'hF8;
         8'd8:    seg7 = 8'h80;
         8'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
   logic                   r_sclk_prev, r_ss_prev;
   state_t                 r_state, w_state_nxt;
   logic [2:0]             r_bit_cnt;
   logic [6:0]             r_shift;
   logic [7:0]             r_high, r_low;
   logic [15:0]            r_disp;
   logic                   r_valid, r_err, w_valid_nxt, w_err_nxt;
   logic [CW-1:0]          r_scan;
   logic [1:0]             r_idx;
   logic [3:0]             r_com;
   logic [7:0]             r_data;

   logic       w_sclk, w_mosi, w_ss;
   logic       w_sclk_rise, w_ss_fall, w_ss_rise, w_last_bit, w_bytes_ok;
   logic [7:0] w_byte, w_sel, w_tens, w_ones, w_digit;
   logic [3:0] w_com;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss        = r_ss_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_prev & ~w_ss;
   assign w_ss_fall   = ~w_ss & r_ss_prev;
   assign w_ss_rise   = w_ss & ~r_ss_prev;
   assign w_byte      = {r_shift, w_mosi};
   assign w_last_bit  = (r_bit_cnt == 3'd7);
   assign w_bytes_ok  = (r_high <= 8'd99) && (r_low <= 8'd99);

   // Input synchronisers plus one extra flop for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sclk_sync <= {SYNC_STAGES{1'b0}};
         r_mosi_sync <= {SYNC_STAGES{1'b0}};
         r_ss_sync   <= {SYNC_STAGES{1'b1}};
         r_sclk_prev <= 1'b0;
         r_ss_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_N};
         r_sclk_prev <= w_sclk;
         r_ss_prev   <= w_ss;
      end
   end

   // Frame FSM next-state and result pulses
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ss_fall) w_state_nxt = RX_HIGH;
            else           w_state_nxt = IDLE;
         end
         RX_HIGH: begin
            if (w_ss_rise) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end else if (w_sclk_rise && w_last_bit) begin
               w_state_nxt = RX_LOW;
            end else begin
               w_state_nxt = RX_HIGH;
            end
         end
         RX_LOW: begin
            if (w_ss_rise) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end else if (w_sclk_rise && w_last_bit) begin
               w_state_nxt = WAIT_END;
            end else begin
               w_state_nxt = RX_LOW;
            end
         end
         WAIT_END: begin
            if (w_ss_rise) begin
               w_state_nxt = COMMIT;
               w_valid_nxt = w_bytes_ok;
               w_err_nxt   = ~w_bytes_ok;
            end else begin
               w_state_nxt = WAIT_END;
            end
         end
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Frame state, receive datapath and display register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_shift   <= 7'd0;
         r_high    <= 8'd0;
         r_low     <= 8'd0;
         r_disp    <= 16'd0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         if (r_state == IDLE && w_ss_fall) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
         end else if ((r_state == RX_HIGH || r_state == RX_LOW) && w_sclk_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit && r_state == RX_HIGH) r_high <= w_byte;
            else if (w_last_bit)                  r_low  <= w_byte;
         end
         if (r_state == COMMIT && w_bytes_ok) r_disp <= {r_high, r_low};
      end
   end

   // Digit index 0/1 come from the low byte, 2/3 from the high byte
   assign w_sel   = r_idx[1] ? r_disp[15:8] : r_disp[7:0];
   assign w_tens  = w_sel / 8'd10;
   assign w_ones  = w_sel % 8'd10;
   assign w_digit = r_idx[0] ? w_tens : w_ones;
   assign w_com   = ~(4'b0001 << r_idx);

   // Digit scan timer and registered display drives
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan <= {CW{1'b0}};
         r_idx  <= 2'd0;
         r_com  <= 4'b1110;
         r_data <= 8'hC0;
      end else begin
         if (r_scan == SCAN_LAST) begin
            r_scan <= {CW{1'b0}};
            r_idx  <= r_idx + 2'd1;
         end else begin
            r_scan <= r_scan + CW'(1);
         end
         r_com  <= w_com;
         r_data <= seg7(w_digit);
      end
   end

   assign MISO        = 1'b0;
   assign fnd_com     = r_com;
   assign fnd_data    = r_data;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;

endmodule

// File: tb/tb_spi_fnd_slave.sv
// Directed bench for spi_fnd_slave: frame vectors from a table, plus reset and
// scan-timing sequences, all with hand-computed expected display contents.
`timescale 1ns/1ps
module tb_spi_fnd_slave;

   localparam int SCAN_DIV = 4;

   typedef struct {
      string       name;
      logic [31:0] bits;
      int          nbits;
      int          half;
      int          exp_valid;
      int          exp_err;
      logic [15:0] exp_disp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, SCLK, MOSI, SS_N;
   logic       MISO, frame_valid, frame_err;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_err = 0;

   logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   vec_t vecs [10];

   spi_fnd_slave #(.SYNC_STAGES(2), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N),
      .MISO(MISO), .fnd_com(fnd_com), .fnd_data(fnd_data),
      .frame_valid(frame_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset) begin
         if (frame_valid) n_valid++;
         if (frame_err) n_err++;
         if (frame_valid && frame_err) begin
            errors++;
            $display("FAIL both_pulses at %0t: frame_valid=1 frame_err=1 required not both", $time);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", nm, got, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] bits, input int nbits, input int half);
      for (int i = nbits - 1; i >= 0; i--) begin
         MOSI = bits[i];
         wait_clk(half);
         SCLK = 1'b1;
         wait_clk(half);
         SCLK = 1'b0;
      end
   endtask

   task automatic check_display(input logic [15:0] exp, input string nm);
      logic [3:0] seen;
      logic [3:0] dig;
      int idx;
      seen = 4'b0000;
      for (int c = 0; c < 8 * SCAN_DIV; c++) begin
         @(negedge clk);
         case (fnd_com)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         checks++;
         if (idx < 0) begin
            errors++;
            $display("FAIL %s fnd_com got %b required one-hot-low", nm, fnd_com);
         end else begin
            dig = exp[idx*4 +: 4];
            seen[idx] = 1'b1;
            if (fnd_data !== segtab[dig]) begin
               errors++;
               $display("FAIL %s digit%0d fnd_data got %h required %h", nm, idx, fnd_data, segtab[dig]);
            end
         end
      end
      chk({nm, " digits_seen"}, {28'd0, seen}, 32'hF);
   endtask

   task automatic run_vec(input vec_t v);
      int v0;
      int e0;
      v0 = n_valid;
      e0 = n_err;
      SS_N = 1'b0;
      wait_clk(v.half);
      send_bits(v.bits, v.nbits, v.half);
      wait_clk(v.half);
      SS_N = 1'b1;
      MOSI = 1'b0;
      wait_clk(8);
      chk({v.name, " valid_pulses"}, n_valid - v0, v.exp_valid);
      chk({v.name, " err_pulses"}, n_err - e0, v.exp_err);
      check_display(v.exp_disp, v.name);
   endtask

   initial begin
      vec_t   v;
      int     v0;
      int     e0;
      logic [3:0] exp_com;

      vecs[0] = '{"frame_0c22",  32'h0000_0C22, 16, 50, 1, 0, 16'h1234};
      vecs[1] = '{"frame_6363",  32'h0000_6363, 16, 6,  1, 0, 16'h9999};
      vecs[2] = '{"frame_0000",  32'h0000_0000, 16, 6,  1, 0, 16'h0000};
      vecs[3] = '{"frame_6405",  32'h0000_6405, 16, 6,  0, 1, 16'h0000};
      vecs[4] = '{"frame_0562",  32'h0000_0562, 16, 6,  1, 0, 16'h0598};
      vecs[5] = '{"abort_11b",   32'h0000_0555, 11, 6,  0, 1, 16'h0598};
      vecs[6] = '{"frame_002a",  32'h0000_002A, 16, 6,  1, 0, 16'h0042};
      vecs[7] = '{"extra_20b",   32'h0000_102F, 20, 6,  1, 0, 16'h0102};
      vecs[8] = '{"frame_0064",  32'h0000_0064, 16, 6,  0, 1, 16'h0102};
      vecs[9] = '{"frame_6300",  32'h0000_6300, 16, 6,  1, 0, 16'h9900};

      reset = 1'b0;
      SCLK  = 1'b0;
      MOSI  = 1'b0;
      SS_N  = 1'b1;
      wait_clk(4);
      chk("rst_com", {28'd0, fnd_com}, 32'hE);
      chk("rst_data", {24'd0, fnd_data}, 32'hC0);
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_miso", {31'd0, MISO}, 32'd0);
      reset = 1'b1;
      wait_clk(4);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      chk("miso_idle", {31'd0, MISO}, 32'd0);

      // reset during bit 5 of the low byte
      v0 = n_valid;
      e0 = n_err;
      SS_N = 1'b0;
      wait_clk(6);
      send_bits(32'h0000_0123, 12, 6);
      MOSI = 1'b1;
      wait_clk(6);
      SCLK = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      SCLK = 1'b0;
      SS_N = 1'b1;
      MOSI = 1'b0;
      wait_clk(1);
      chk("midrst_com", {28'd0, fnd_com}, 32'hE);
      chk("midrst_data", {24'd0, fnd_data}, 32'hC0);
      chk("midrst_valid", {31'd0, frame_valid}, 32'd0);
      chk("midrst_err", {31'd0, frame_err}, 32'd0);
      chk("midrst_miso", {31'd0, MISO}, 32'd0);
      wait_clk(4);
      reset = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         exp_com = 4'b1111 ^ (4'b0001 << ((n - 1) / 4));
         chk($sformatf("scan_com_c%0d", n), {28'd0, fnd_com}, {28'd0, exp_com});
         chk($sformatf("scan_data_c%0d", n), {24'd0, fnd_data}, 32'hC0);
      end
      chk("midrst_no_valid", n_valid - v0, 32'd0);
      chk("midrst_no_err", n_err - e0, 32'd0);

      v = '{"after_rst_0007", 32'h0000_0007, 16, 6, 1, 0, 16'h0007};
      run_vec(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_fnd_slave.md
SPI_FND_SLAVE -- requirements
Module: spi_fnd_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on SCLK, MOSI and SS_N.
REQ-002 Parameter SCAN_DIV, default 100_000: clk cycles each FND digit stays enabled.
REQ-003 The module has one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 SCLK  input  1  SPI clock, CPOL=0, asynchronous to clk.
REQ-007 MOSI  input  1  SPI data, MSB first, stable around SCLK rising edge.
REQ-008 SS_N  input  1  frame select, active low; one frame = 2 bytes (high byte, then low byte).
REQ-009 MISO  output  1  driven constant 0; the slave sends no read data.
REQ-010 fnd_com  output  4  digit enables, active low; bit0 = ones digit.
REQ-011 fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active low.
REQ-012 frame_valid  output  1  one-clk pulse when a good frame is committed.
REQ-013 frame_err  output  1  one-clk pulse when a frame is discarded.

Function
REQ-014 The module shall pass SCLK, MOSI and SS_N through SYNC_STAGES flops before any use, and detect edges on the synchronised signals only.
REQ-015 Timing constraint: SCLK high and low phases are each at least SYNC_STAGES+2 clk cycles.
REQ-016 FSM states:
- IDLE
- RX_HIGH
- RX_LOW
- WAIT_END
- COMMIT
REQ-017 IDLE -> RX_HIGH on synchronised SS_N falling edge; bit counter (3 b) and shift register are cleared.
REQ-018 Sampling: on each synchronised SCLK rising edge while SS_N is low, shift = {shift[6:0], MOSI}.
REQ-019 The 8th sample in RX_HIGH stores high_byte and enters RX_LOW; the 8th sample in RX_LOW stores low_byte and enters WAIT_END.
REQ-020 In WAIT_END, further SCLK edges shall be ignored; synchronised SS_N rising enters COMMIT.
REQ-021 COMMIT lasts exactly one cycle, then returns to IDLE:
- high_byte<=99 and low_byte<=99: display register <= {high_byte, low_byte}, frame_valid=1.
- otherwise: display register unchanged, frame_err=1.
REQ-022 SS_N rising in RX_HIGH or RX_LOW (incomplete frame) shall discard all received bits, pulse frame_err for one cycle and go to IDLE; the display is unchanged.
REQ-023 frame_valid/frame_err shall assert exactly 1 clk after the synchronised SS_N rising edge is detected, and never both in the same cycle.
REQ-024 Digits from the display register:
- d3 = high/10, d2 = high%10
- d1 = low/10, d0 = low%10
- each value is 0..9.
REQ-025 The 7-segment decode shall be the standard active-low decode (0=C0h, 1=F9h, 2=A4h, 3=B0h, 4=99h, 5=92h, 6=82h, 7=F8h, 8=80h, 9=90h), with dp always 1 (off).
REQ-026 The scan counter shall count 0..SCAN_DIV-1 and wrap; at each wrap the digit index advances 0->1->2->3->0.
REQ-027 fnd_com shall be registered with exactly one bit low (1110, 1101, 1011, 0111 for index 0..3); fnd_data shall be registered and always match the enabled digit.
REQ-028 The display register shall update only in COMMIT and shall not reset the scan position.

Reset
REQ-029 While reset=0, the module shall hold:
- FSM = IDLE, bit counter = 0, shift/high_byte/low_byte = 0
- synchronisers = SS_N high, SCLK low, MOSI low
- display register = 0, scan counter = 0, digit index = 0
- fnd_com = 1110, fnd_data = C0h, frame_valid = 0, frame_err = 0, MISO = 0.
REQ-030 Reset asserted mid-frame shall abort the frame with no pulse; the first complete frame after release shall be accepted normally.

Verification
REQ-031 Frame 0Ch,22h (SCLK half period 50 clk), then SS_N high -> one frame_valid pulse; digits 1,2,3,4; fnd_data = F9h/A4h/B0h/99h with fnd_com 0111/1011/1101/1110.
REQ-032 Frame 63h,63h -> 9999 shown (all digits 90h); then frame 00h,00h -> all digits C0h.
REQ-033 Frame 64h,05h -> frame_err pulse, no frame_valid, previous display value retained.
REQ-034 SS_N rises after 11 bits -> frame_err pulse; the following full frame 00h,2Ah -> display 0042.
REQ-035 20 SCLK pulses within one SS_N low window carrying 01h,02h, then 4 extra bits -> display 0102, one frame_valid pulse.
REQ-036 reset=0 during bit 5 of the low byte -> reset values of REQ-029; a scan of 4*SCAN_DIV cycles with SCAN_DIV=4 shows fnd_com 1110,1101,1011,0111, each held 4 cycles.
